// File: rtl/uart_pkg.sv
// Shared UART receive-side definitions.
//   UART_OVERSAMPLE : sample ticks per bit
//   UART_FRAME_BITS : start + 8 data + stop
//   TICKS_PER_CHAR  : sample ticks per character time
//   rx_ctrl_state_t : capture FSM states of uart_rx_ctrl
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FRAME_BITS = 10;
    localparam int TICKS_PER_CHAR  = UART_OVERSAMPLE * UART_FRAME_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2
    } rx_ctrl_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, registered write, combinational head read.
//   clk, reset          : clock, synchronous active-high reset (flushes pointers/count)
//   i_wr_en, i_wr_data  : write request; accepted when not full, or when full
//                         and a read pops in the same cycle
//   i_rd_en             : pop head when not empty
//   o_rd_data           : head byte, 0 while empty
//   o_full, o_empty     : occupancy flags
//   o_count             : occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_fire, rd_fire;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_MAX);
    assign rd_fire = i_rd_en && !o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_fire = i_wr_en && (!o_full || rd_fire);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_fire && !rd_fire)      count_d = count_q + CNT_ONE;
        else if (rd_fire && !wr_fire) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];
    assign o_count   = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame check, byte FIFO, sticky errors, idle gap.
//   clk, reset            : clock, synchronous active-high reset
//   i_clk_rx              : 16x baud sample tick
//   i_rx_done, i_rx_data  : frame-complete pulse with its byte
//   i_rx_stop             : stop-bit sample, valid one clk after i_rx_done
//   i_rd_ready            : consumer pops the FIFO head
//   o_rd_valid, o_rd_data : FIFO head
//   o_count               : FIFO occupancy
//   o_frame_err           : sticky, stop bit sampled low
//   o_overrun             : sticky, a byte was lost
//   o_idle_to             : one-clk pulse after an idle gap following a byte
//   i_clr_err             : clears the sticky flags (a same-cycle set wins)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter bit DROP_BAD   = 1'b1,
    parameter int IDLE_CHARS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clk_rx,
    input  logic                   i_rx_done,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_stop,
    input  logic                   i_rd_ready,
    output logic                   o_rd_valid,
    output logic [7:0]             o_rd_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_idle_to,
    input  logic                   i_clr_err
);

    localparam int IDLE_TICKS = IDLE_CHARS * TICKS_PER_CHAR;
    localparam int TW = $clog2(IDLE_TICKS + 1);
    localparam logic [TW-1:0] IDLE_MAX = IDLE_TICKS;
    localparam logic [TW-1:0] TICK_ONE = 1;

    rx_ctrl_state_t state_q, state_d;
    logic [7:0]     hold_q, hold_d, pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;
    logic           frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [TW-1:0]  idle_cnt_q, idle_cnt_d;
    logic           armed_q, armed_d, idle_to_q, idle_to_d;

    logic wr_en, fe_set, finish, busy, take_pend, take_new, load_pend, pend_drop;
    logic fifo_full, fifo_empty, fifo_drop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_rx_done) state_d = CHECK;
            CHECK:   if (finish) state_d = (take_pend || take_new) ? CHECK : IDLE;
                     else        state_d = COMMIT;
            COMMIT:  state_d = (take_pend || take_new) ? CHECK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // finish marks the last cycle spent on the held byte (written or dropped).
    always_comb begin
        wr_en  = 1'b0;
        fe_set = 1'b0;
        finish = 1'b0;
        case (state_q)
            CHECK: begin
                fe_set = !i_rx_stop;
                finish = !i_rx_stop && DROP_BAD;
            end
            COMMIT: begin
                wr_en  = 1'b1;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- holding slots ----------------
    // A pulse landing while busy parks in the pending slot; if the held byte
    // finishes in that same cycle and nothing is parked, the new byte goes
    // straight to the holding register so it is never stranded.
    always_comb begin
        busy      = (state_q != IDLE);
        take_pend = finish && pend_vld_q;
        take_new  = i_rx_done && (!busy || (finish && !pend_vld_q));
        load_pend = i_rx_done && busy && !take_new;
        pend_drop = load_pend && pend_vld_q && !take_pend;

        hold_d     = take_pend ? pend_q : (take_new ? i_rx_data : hold_q);
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (take_pend) pend_vld_d = 1'b0;
        if (load_pend && !pend_drop) begin
            pend_d     = i_rx_data;
            pend_vld_d = 1'b1;
        end
    end

    // ---------------- FIFO ----------------
    uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (wr_en),
        .i_wr_data (hold_q),
        .i_rd_en   (i_rd_ready),
        .o_rd_data (o_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (o_count)
    );

    // Full implies non-empty, so a ready consumer always frees a slot.
    assign fifo_drop  = wr_en && fifo_full && !i_rd_ready;
    assign o_rd_valid = !fifo_empty;

    // ---------------- sticky flags and idle detector ----------------
    always_comb begin
        frame_err_d = fe_set | (frame_err_q & ~i_clr_err);
        overrun_d   = fifo_drop | pend_drop | (overrun_q & ~i_clr_err);

        idle_cnt_d = idle_cnt_q;
        armed_d    = armed_q;
        idle_to_d  = 1'b0;
        if (i_rx_done) begin
            idle_cnt_d = '0;
            armed_d    = 1'b1;
        end else if (i_clk_rx && idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + TICK_ONE;
            if (armed_q && idle_cnt_d == IDLE_MAX) begin
                idle_to_d = 1'b1;
                armed_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            idle_cnt_q  <= '0;
            armed_q     <= 1'b0;
            idle_to_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            idle_cnt_q  <= idle_cnt_d;
            armed_q     <= armed_d;
            idle_to_q   <= idle_to_d;
        end
    end

    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_idle_to   = idle_to_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a DROP_BAD=1 instance carries most checks, a
// DROP_BAD=0 instance sharing the receive stimulus covers the store-anyway mode.
module tb_uart_rx_ctrl;

    localparam int DEPTH      = 16;
    localparam int IDLE_TICKS = 320;

    logic       clk = 1'b0, reset = 1'b1, clk_rx = 1'b0, rx_done = 1'b0, rx_stop = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rd_ready = 1'b0, rd_ready2 = 1'b0, clr_err = 1'b0;

    logic       rd_valid, frame_err, overrun, idle_to;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       v2, fe2, ov2, it2;
    logic [7:0] d2;
    logic [4:0] c2;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_BAD(1'b1), .IDLE_CHARS(2)) dut (
        .clk(clk), .reset(reset), .i_clk_rx(clk_rx), .i_rx_done(rx_done),
        .i_rx_data(rx_data), .i_rx_stop(rx_stop), .i_rd_ready(rd_ready),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_count(count),
        .o_frame_err(frame_err), .o_overrun(overrun), .o_idle_to(idle_to),
        .i_clr_err(clr_err)
    );

    uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_BAD(1'b0), .IDLE_CHARS(2)) dut2 (
        .clk(clk), .reset(reset), .i_clk_rx(clk_rx), .i_rx_done(rx_done),
        .i_rx_data(rx_data), .i_rx_stop(rx_stop), .i_rd_ready(rd_ready2),
        .o_rd_valid(v2), .o_rd_data(d2), .o_count(c2),
        .o_frame_err(fe2), .o_overrun(ov2), .o_idle_to(it2),
        .i_clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, pulses = 0;
    logic [7:0] q1[$], q2[$];
    logic       ov_exp = 1'b0;

    // Counts cycles during which o_idle_to is high (sampled before each edge).
    always @(posedge clk) if (idle_to) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [4:0] exp_cnt;
        logic       exp_fe;
        logic [4:0] exp_cnt2;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        q1.delete(); q2.delete(); ov_exp = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); clk_rx = 1'b1;
        @(negedge clk); clk_rx = 1'b0;
    endtask

    // Full frame: pulse, stop sample next clk, then one clk for the write.
    task automatic send(input logic [7:0] d, input logic s);
        @(negedge clk); rx_done = 1'b1; rx_data = d;
        @(negedge clk); rx_done = 1'b0; rx_stop = s;
        @(negedge clk); rx_stop = 1'b1;
        @(negedge clk);
        if (s) begin
            if (q1.size() < DEPTH) q1.push_back(d);
            else ov_exp = 1'b1;
        end
        if (q2.size() < DEPTH) q2.push_back(d);
    endtask

    task automatic pop(input bit sel, input string nm);
        logic [7:0] e;
        if ((sel ? q2.size() : q1.size()) == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: got no expected byte, required one queued", nm);
            return;
        end
        if (sel) begin
            e = q2.pop_front();
            chk({nm, " valid"}, 32'(v2), 32'd1);
            chk({nm, " data"}, 32'(d2), 32'(e));
            rd_ready2 = 1'b1; @(negedge clk); rd_ready2 = 1'b0;
        end else begin
            e = q1.pop_front();
            chk({nm, " valid"}, 32'(rd_valid), 32'd1);
            chk({nm, " data"}, 32'(rd_data), 32'(e));
            rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
        end
    endtask

    initial begin
        int p0;
        vecs[0] = '{8'hA5, 1'b1, 5'd1, 1'b0, 5'd1};
        vecs[1] = '{8'h3C, 1'b0, 5'd1, 1'b1, 5'd2};
        vecs[2] = '{8'h5A, 1'b1, 5'd2, 1'b1, 5'd3};
        vecs[3] = '{8'hFF, 1'b1, 5'd3, 1'b1, 5'd4};
        vecs[4] = '{8'h00, 1'b0, 5'd3, 1'b1, 5'd5};

        // ---- reset state ----
        do_reset();
        chk("rst valid", 32'(rd_valid), 0);
        chk("rst data", 32'(rd_data), 0);
        chk("rst count", 32'(count), 0);
        chk("rst frame_err", 32'(frame_err), 0);
        chk("rst overrun", 32'(overrun), 0);
        chk("rst idle_to", 32'(idle_to), 0);

        // ---- single good byte, latency ----
        @(negedge clk); rx_done = 1'b1; rx_data = 8'hA5;
        @(negedge clk); rx_done = 1'b0; chk("lat +1 valid", 32'(rd_valid), 0);
        @(negedge clk); chk("lat +2 valid", 32'(rd_valid), 0);
        @(negedge clk); chk("lat +3 valid", 32'(rd_valid), 1);
        chk("lat count", 32'(count), 1);
        q1.push_back(8'hA5);
        pop(0, "single");
        chk("single count after pop", 32'(count), 0);

        // ---- table: good and bad frames, both DROP_BAD modes ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, vecs[i].stop);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_fe));
            chk($sformatf("vec%0d count keep", i), 32'(c2), 32'(vecs[i].exp_cnt2));
            chk($sformatf("vec%0d frame_err keep", i), 32'(fe2), 32'(vecs[i].exp_fe));
        end
        while (q1.size() != 0) pop(0, "drop-mode drain");
        chk("drop-mode drained", 32'(count), 0);
        while (q2.size() != 0) pop(1, "keep-mode drain");
        chk("keep-mode drained", 32'(c2), 0);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("clr frame_err", 32'(frame_err), 0);
        chk("clr frame_err keep", 32'(fe2), 0);

        // ---- clear coinciding with a framing error: set wins ----
        @(negedge clk); rx_done = 1'b1; rx_data = 8'h3C;
        @(negedge clk); rx_done = 1'b0; rx_stop = 1'b0; clr_err = 1'b1;
        @(negedge clk); rx_stop = 1'b1; clr_err = 1'b0;
        chk("set beats clear", 32'(frame_err), 1);

        // ---- overrun: 17 bytes into 16 ----
        do_reset();
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b1);
        chk("ovr count", 32'(count), 16);
        chk("ovr flag", 32'(overrun), 32'(ov_exp));
        for (int i = 0; i < 16; i++) pop(0, $sformatf("ovr read %0d", i));
        chk("ovr drained", 32'(count), 0);
        chk("ovr sticky", 32'(overrun), 1);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("ovr cleared", 32'(overrun), 0);

        // ---- full FIFO, write coincides with read ----
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1);
        chk("full count", 32'(count), 16);
        q1.push_back(8'hEE);
        @(negedge clk); rx_done = 1'b1; rx_data = 8'hEE;
        @(negedge clk); rx_done = 1'b0;
        @(negedge clk); chk("full head", 32'(rd_data), 32'(q1.pop_front())); rd_ready = 1'b1;
        @(negedge clk); rd_ready = 1'b0;
        chk("full+rd count", 32'(count), 16);
        chk("full+rd overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) pop(0, $sformatf("full read %0d", i));
        chk("full drained", 32'(count), 0);

        // ---- idle gap ----
        do_reset();
        send(8'h11, 1'b1);
        p0 = pulses;
        repeat (IDLE_TICKS - 1) tick();
        repeat (2) @(negedge clk);
        chk("idle no pulse at 319", 32'(pulses - p0), 0);
        tick();
        repeat (2) @(negedge clk);
        chk("idle pulse at 320", 32'(pulses - p0), 1);
        repeat (400) tick();
        repeat (2) @(negedge clk);
        chk("idle no repeat", 32'(pulses - p0), 1);
        send(8'h22, 1'b1);
        p0 = pulses;
        repeat (IDLE_TICKS - 1) tick();
        send(8'h33, 1'b1);
        repeat (IDLE_TICKS - 1) tick();
        repeat (2) @(negedge clk);
        chk("idle restart no pulse", 32'(pulses - p0), 0);
        tick();
        repeat (2) @(negedge clk);
        chk("idle restart pulse", 32'(pulses - p0), 1);

        // ---- reset mid-operation ----
        do_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        chk("pre-reset count", 32'(count), 5);
        @(negedge clk); rx_done = 1'b1; rx_data = 8'h77;
        @(negedge clk); rx_done = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        q1.delete(); q2.delete();
        chk("mid-rst valid", 32'(rd_valid), 0);
        chk("mid-rst data", 32'(rd_data), 0);
        chk("mid-rst count", 32'(count), 0);
        chk("mid-rst frame_err", 32'(frame_err), 0);
        chk("mid-rst overrun", 32'(overrun), 0);
        chk("mid-rst idle_to", 32'(idle_to), 0);
        chk("mid-rst keep count", 32'(c2), 0);
        chk("mid-rst keep flags", 32'({v2, fe2, ov2, it2}), 0);
        repeat (3) @(negedge clk);
        chk("mid-rst no late write", 32'(count), 0);
        send(8'h5A, 1'b1);
        chk("post-rst count", 32'(count), 1);
        pop(0, "post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART byte receiver and the host/bus logic. It consumes the receiver's per-frame done pulse, data byte and stop-bit sample, and checks each frame for a framing error. Accepted bytes go into a small synchronous FIFO with a valid/ready read port. It also keeps sticky error status and detects line-idle gaps, measured in 16x baud ticks, so the host can detect end of message.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2
DROP_BAD, 1, 1 = discard bytes with a framing error; 0 = store them anyway (error still flagged)
IDLE_CHARS, 2, idle gap length in character times (1 char = 160 ticks of i_clk_rx)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_clk_rx  in  1  16x-baud sample tick, 1 clk wide
i_rx_done  in  1  receiver frame-complete pulse, 1 clk wide
i_rx_data  in  8  receiver data byte; valid in the cycle of i_rx_done
i_rx_stop  in  1  receiver stop-bit sample; valid 1 clk after i_rx_done
i_rd_ready  in  1  consumer accepts o_rd_data this cycle
o_rd_valid  out  1  FIFO not empty
o_rd_data  out  8  FIFO head byte
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_frame_err  out  1  sticky: a stop bit was sampled low
o_overrun  out  1  sticky: a byte was lost because the FIFO was full
o_idle_to  out  1  1-clk pulse when the idle gap is detected
i_clr_err  in  1  clears o_frame_err and o_overrun

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state is updated only on posedge clk.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, idle counter 0, armed flag 0.
- Capture FSM, three states:
  - IDLE: on i_rx_done, latch i_rx_data into a holding register and go to CHECK.
  - CHECK: exactly one cycle. Sample i_rx_stop.
    - If i_rx_stop=0: set o_frame_err. If DROP_BAD=1, go to IDLE with no write.
    - Otherwise go to COMMIT.
  - COMMIT: issue one FIFO write of the holding byte, then go to IDLE.
- Capture latency: a good byte reaches o_rd_valid 3 clk after i_rx_done (IDLE to CHECK to COMMIT, plus the registered FIFO write).
- If i_rx_done arrives while the FSM is in CHECK or COMMIT: latch the new byte into a second holding slot and process it immediately after. A third overlapping pulse is dropped and sets o_overrun. This cannot occur at legal baud rates.
- FIFO write rules:
  - Accepted if count < DEPTH.
  - Also accepted if count == DEPTH and a read occurs in the same cycle; count is then unchanged.
  - Otherwise the byte is dropped and o_overrun is set.
- FIFO read: when o_rd_valid && i_rd_ready, the head pops and the next byte appears on the next clk. o_rd_data holds its value while o_rd_valid=1 and i_rd_ready=0.
- Pointers: width $clog2(DEPTH), wrap modulo DEPTH.
- o_count: changes by +1, -1 or 0 per clk. A simultaneous read and write with 0 < count < DEPTH leaves it unchanged.
- Sticky flags: when i_clr_err coincides with a new error event, the set wins and the flag stays 1.
- Idle detector:
  - Counter clears on every i_rx_done and increments on each i_clk_rx, saturating at IDLE_CHARS*160.
  - The armed flag is set by i_rx_done.
  - When the counter reaches IDLE_CHARS*160 while armed: pulse o_idle_to for 1 clk and clear armed.
  - No repeat pulse until the next byte arrives.
- Mid-operation reset: FIFO is flushed, the byte held in CHECK or COMMIT is discarded, and flags and counters return to 0.

Decomposition:
- Shared package uart_pkg:
  - UART_OVERSAMPLE=16
  - UART_FRAME_BITS=10
  - TICKS_PER_CHAR=160
  - rx_ctrl_state_t enum (IDLE, CHECK, COMMIT)
- One sub-module, uart_sync_fifo: parameterised width/depth, write/read with full/empty flags and count, synchronous active-high reset.
- The FSM, error flags and idle detector live in uart_rx_ctrl.

Test Plan:
- Single good byte: i_rx_done with data 0xA5, stop=1 one clk later -> o_rd_valid=1 exactly 3 clk after the pulse, o_rd_data=0xA5, o_count=1; i_rd_ready pops it -> o_count=0.
- Framing error, DROP_BAD=1: data 0x3C, stop=0 -> o_frame_err=1, o_count stays 0; i_clr_err -> o_frame_err=0. Repeat with DROP_BAD=0 -> byte 0x3C is stored and the flag is set.
- Overrun: write bytes 0x00..0x10 (17 bytes, DEPTH=16) with i_rd_ready=0 -> o_count=16, o_overrun=1; read-out order is 0x00..0x0F.
- Full with simultaneous read: FIFO full, a COMMIT write coincides with i_rd_ready=1 -> count stays 16, o_overrun stays 0, new byte is last out.
- Idle gap, IDLE_CHARS=2: one byte, then 320 i_clk_rx ticks -> a single o_idle_to pulse on the 320th tick. A byte arriving at tick 319 -> no pulse, counter restarts. No second pulse without a new byte.
- Reset with 5 bytes queued and the FSM in CHECK -> all outputs 0 on the next clk; a following good byte 0x5A -> o_count=1.
